// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter merging several write-back sources onto
// regfile write port 0.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   rst        - asynchronous active-high reset
//   req_valid  - [REQUESTERS] source i holds a pending register write
//   req_addr   - [REQUESTERS*5] packed destination registers (source i at bits i*5 +: 5)
//   req_data   - [REQUESTERS*32] packed write data (source i at bits i*32 +: 32)
//   req_ready  - [REQUESTERS] write of source i accepted this cycle (one-hot or zero)
//   wb_addr    - registered write address (0 when idle or when x0 was targeted)
//   wb_data    - registered write data (0 when idle or when x0 was targeted)
//   wb_valid   - wb_addr/wb_data carry a real write
//   grant_id   - index of the source whose write is on wb_*
module wb_arbiter #(
   parameter int REQUESTERS = 3,
   parameter int IDX_W      = $clog2(REQUESTERS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REQUESTERS-1:0]    req_valid,
   input  logic [REQUESTERS*5-1:0]  req_addr,
   input  logic [REQUESTERS*32-1:0] req_data,
   output logic [REQUESTERS-1:0]    req_ready,
   output logic [4:0]               wb_addr,
   output logic [31:0]              wb_data,
   output logic                     wb_valid,
   output logic [IDX_W-1:0]         grant_id
);

   logic [IDX_W-1:0]      ptr;
   logic [REQUESTERS-1:0] rot;
   logic                  found;
   logic [IDX_W:0]        off;
   logic [IDX_W:0]        sum;
   logic [IDX_W-1:0]      gnt_idx;
   logic [4:0]            sel_addr;
   logic [31:0]           sel_data;

   // Rotate the request vector so that bit 0 is the source at ptr; the first
   // set bit is then the offset of the winner from ptr.
   always_comb begin
      rot      = REQUESTERS'({req_valid, req_valid} >> ptr);
      found    = 1'b0;
      off      = '0;
      sum      = '0;
      gnt_idx  = '0;
      req_ready = '0;
      for (int unsigned j = 0; j < REQUESTERS; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            off   = (IDX_W+1)'(j);
         end
      end
      sum = {1'b0, ptr} + off;
      if (sum >= (IDX_W+1)'(REQUESTERS))
         sum = sum - (IDX_W+1)'(REQUESTERS);
      gnt_idx = sum[IDX_W-1:0];
      // No transfers are allowed while reset is held.
      if (found && !rst)
         req_ready = REQUESTERS'(1) << gnt_idx;
   end

   assign sel_addr = req_addr[int'(gnt_idx)*5 +: 5];
   assign sel_data = req_data[int'(gnt_idx)*32 +: 32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         grant_id <= '0;
      end else begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         grant_id <= '0;
         if (found) begin
            ptr <= (gnt_idx == IDX_W'(REQUESTERS-1)) ? '0 : gnt_idx + 1'b1;
            // A write to x0 is consumed but suppressed so it never feeds back.
            if (sel_addr != 5'd0) begin
               wb_valid <= 1'b1;
               wb_addr  <= sel_addr;
               wb_data  <= sel_data;
               grant_id <= gnt_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [14:0] req_addr  = '0;
   logic [95:0] req_data  = '0;
   logic [2:0]  req_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_valid;
   logic [1:0]  grant_id;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  g;
      logic        chk_g;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   wb_arbiter #(.REQUESTERS(3), .IDX_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready),
      .wb_addr(wb_addr), .wb_data(wb_data), .wb_valid(wb_valid),
      .grant_id(grant_id)
   );

   // Monitor: one cycle after each driven cycle, compare wb_* with the
   // expectation the driver queued for it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if (wb_valid !== e.v || wb_addr !== e.a || wb_data !== e.d ||
                (e.chk_g && grant_id !== e.g)) begin
               mismatched++;
               $display("FAIL %s: got v=%0b a=%0d d=%h g=%0d, want v=%0b a=%0d d=%h g=%0d",
                        e.name, wb_valid, wb_addr, wb_data, grant_id, e.v, e.a, e.d, e.g);
            end
         end
      end
   end

   task automatic check_now(input string name, input logic [2:0] exp_rdy, input logic ev,
                            input logic [4:0] ea, input logic [31:0] ed);
      compared++;
      if (req_ready !== exp_rdy || wb_valid !== ev || wb_addr !== ea || wb_data !== ed) begin
         mismatched++;
         $display("FAIL %s: got rdy=%b v=%0b a=%0d d=%h, want rdy=%b v=%0b a=%0d d=%h",
                  name, req_ready, wb_valid, wb_addr, wb_data, exp_rdy, ev, ea, ed);
      end
   endtask

   // Drive one cycle at negedge, check req_ready, queue next-cycle output.
   task automatic drive(input string name, input logic [2:0] v,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [2:0] exp_rdy, input logic ev, input logic [4:0] ea,
                        input logic [31:0] ed, input logic [1:0] eg, input logic chk_g);
      exp_t e;
      @(negedge clk);
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
      #1;
      compared++;
      if (req_ready !== exp_rdy) begin
         mismatched++;
         $display("FAIL %s_ready: got %b, want %b", name, req_ready, exp_rdy);
      end
      e.name = name; e.v = ev; e.a = ea; e.d = ed; e.g = eg; e.chk_g = chk_g;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset state, asynchronously, before any clock edge.
      #2;
      check_now("reset_state", 3'b000, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Idle for 5 cycles.
      for (int i = 0; i < 5; i++)
         drive("idle", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1);

      // Single source 1 request.
      drive("single_src1", 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0,
            3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 1'b1);
      drive("idle_after", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1);

      // All three continuously valid from reset: grants 0,1,2,0,1,2.
      do_reset();
      drive("rr0", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 1'b1);
      drive("rr1", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1);
      drive("rr2", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1'b1);
      drive("rr3", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 1'b1);
      drive("rr4", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1);
      drive("rr5", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1'b1);

      // ptr=0 now; grant source 1 to move ptr to 2, then wrap-around.
      drive("set_ptr2", 3'b010, 0, 4, 0, 0, 32'h44, 0, 3'b010, 1'b1, 5'd4, 32'h44, 2'd1, 1'b1);
      drive("wrap_src2", 3'b101, 7, 0, 9, 32'hA0, 0, 32'hA2, 3'b100, 1'b1, 5'd9, 32'hA2, 2'd2, 1'b1);
      drive("wrap_src0", 3'b001, 7, 0, 0, 32'hA0, 0, 0, 3'b001, 1'b1, 5'd7, 32'hA0, 2'd0, 1'b1);

      // ptr=1; write to x0 is accepted but suppressed, ptr moves to 1.
      drive("x0_write", 3'b001, 0, 0, 0, 32'h1234, 0, 0, 3'b001, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0);
      // Idle keeps ptr=1.
      drive("idle_ptr", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1);
      drive("ptr_kept", 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1);
      drive("fair2", 3'b101, 1, 0, 3, 32'h11, 0, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1'b1);
      drive("fair0", 3'b001, 1, 0, 0, 32'h11, 0, 0, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 1'b1);

      // ptr=1; put a valid write on wb_* then reset asynchronously mid-cycle.
      drive("pre_rst", 3'b010, 0, 6, 0, 0, 32'h66, 0, 3'b010, 1'b1, 5'd6, 32'h66, 2'd1, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_now("async_rst", 3'b000, 1'b0, 5'd0, 32'd0);
      req_valid = '0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      // After release, ptr=0: source 0 beats source 1.
      drive("post_rst0", 3'b011, 8, 6, 0, 32'h88, 32'h66, 0, 3'b001, 1'b1, 5'd8, 32'h88, 2'd0, 1'b1);
      drive("post_rst1", 3'b010, 0, 6, 0, 0, 32'h66, 0, 3'b010, 1'b1, 5'd6, 32'h66, 2'd1, 1'b1);
      drive("final_idle", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: REQUESTERS, default 3, number of write-back sources (ALU, LSU, MUL); legal range 2..8.
REQ-002 Parameter: IDX_W, default $clog2(REQUESTERS), width of grant_id.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  [REQUESTERS] x 1  source i holds a pending register write.
REQ-006 req_addr  input  [REQUESTERS] x reg_idx (5)  destination register of source i.
REQ-007 req_data  input  [REQUESTERS] x gpreg (32)  write data of source i.
REQ-008 req_ready  output  [REQUESTERS] x 1  write of source i accepted this cycle.
REQ-009 wb_addr  output  reg_idx (5)  drives regfile write port 0 address.
REQ-010 wb_data  output  gpreg (32)  drives regfile write port 0 data.
REQ-011 wb_valid  output  1  wb_addr/wb_data carry a real write; also qualifies the regfile feedback port.
REQ-012 grant_id  output  IDX_W  index of the source whose write is on wb_* (debug/verification).

Function
REQ-013 Handshake: a transfer from source i occurs in any cycle with req_valid[i]=1 and req_ready[i]=1.
REQ-014 Sources keep req_valid, req_addr and req_data stable until their transfer; the arbiter does not tolerate a valid being retracted.
REQ-015 req_ready is combinational from req_valid and the round-robin pointer; at most one bit of req_ready is high per cycle.
REQ-016 Grant: the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo REQUESTERS.
REQ-017 No valid request: req_ready = all zero and ptr is unchanged.
REQ-018 After a grant to source g, ptr <= (g+1) mod REQUESTERS; the wrap from REQUESTERS-1 goes to 0.
REQ-019 Fairness: a continuously valid source is granted within REQUESTERS cycles.
REQ-020 Latency: 1 cycle; a transfer in cycle N appears on wb_addr/wb_data/wb_valid/grant_id in cycle N+1.
REQ-021 The regfile has no write enable, so in an idle cycle N+1 (no transfer in N): wb_valid=0, wb_addr=0, wb_data=0, grant_id=0. This write to x0 is harmless.
REQ-022 Granted write with req_addr=0: the transfer completes (ready=1), but wb_valid=0 and wb_addr=0, wb_data=0. This blocks bogus feedback of x0.
REQ-023 The output registers have no back-pressure; the arbiter accepts one write every cycle at full throughput.
REQ-024 Simultaneous writes by two sources to the same register: they retire in grant order, and the later grant wins in the regfile.
REQ-025 Data and address pass through unmodified: no width conversion, no sign handling.

Reset
REQ-026 While rst=1: ptr=0, wb_valid=0, wb_addr=0, wb_data=0, grant_id=0, asynchronously, regardless of clk.
REQ-027 While rst=1: req_ready = all zero, so no transfer occurs.
REQ-028 Reset asserted mid-stream: the in-flight output write is discarded, and un-granted requests stay pending at their sources.
REQ-029 First cycle after rst deasserts: arbitration starts from ptr=0.

Verification
REQ-030 Reset, then all req_valid=0 for 5 cycles -> wb_valid=0, wb_addr=0, wb_data=0 every cycle; req_ready=000.
REQ-031 Only source 1 valid, addr=5, data=0xDEADBEEF, cycle N -> req_ready=010 in N; cycle N+1: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF, grant_id=1.
REQ-032 All 3 sources continuously valid (addrs 1,2,3) from reset for 6 cycles -> grants 0,1,2,0,1,2; wb_addr sequence 1,2,3,1,2,3 each lagging by 1 cycle.
REQ-033 ptr=2, sources 0 and 2 valid -> source 2 granted, ptr becomes 0; next cycle source 0 granted (wrap-around).
REQ-034 Source 0 valid, addr=0, data=0x1234 -> req_ready[0]=1; next cycle wb_valid=0, wb_addr=0, wb_data=0.
REQ-035 rst pulsed asynchronously between clock edges while wb_valid=1 -> wb_valid, wb_addr and wb_data go to 0 immediately; after release, the first grant follows ptr=0 order.
